if_fetch_unit: RTL and testbench

Instruction fetch unit: owns the architectural fetch PC, issues in-order 32-bit fetch requests to instruction memory over a valid/ready request channel, and buffers returning instructions in a small FIFO. Its head entry drives the IF/ID pipeline register (stall/flush-controlled). A redirect from execute (branch/jump/trap) discards all in-flight and buffered fetches. When the FIFO is empty it presents a NOP so the IF/ID register never captures garbage.

---
 rtl/if_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch unit with an in-order valid/ready request
// channel, an in-flight PC queue, and an instruction buffer whose head feeds IF/ID.
// A redirect flushes the buffer and discards every response that is still owed.
// Define IFU_MISALIGN_CHECK_EN to flag misaligned redirect targets on misalign_o
// and block fetch until the next aligned redirect.
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic [63:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [63:0] fetchPc_q, fetchPc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] dropCnt_q, dropCnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] fifoWr_q, fifoWr_d, fifoRd_q, fifoRd_d;
  logic [PW-1:0] pcqWr_q, pcqWr_d, pcqRd_q, pcqRd_d;

  logic [63:0] pcQueue_q   [FIFO_DEPTH];
  logic [63:0] fifoPc_q    [FIFO_DEPTH];
  logic [31:0] fifoInstr_q [FIFO_DEPTH];

  logic [63:0] redirectTarget;
  logic        blocked;
  logic        pop;
  logic        room;
  logic        reqFire;
  logic        rspKeep;
  logic        rspDrop;

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign redirectTarget = redirect_pc_i;
  assign blocked        = misalign_q;
  assign misalign_d     = redirect_i ? (redirect_pc_i[1:0] != 2'b00) : misalign_q;
  assign misalign_o     = misalign_q;

  // Misalignment flag is set by a misaligned redirect and held until the next redirect.
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  assign redirectTarget = redirect_pc_i & ~64'h3;
  assign blocked        = 1'b0;
`endif

  assign valid_o         = (count_q != '0);
  assign pc_o            = valid_o ? fifoPc_q[fifoRd_q] : 64'h0;
  assign instr_o         = valid_o ? fifoInstr_q[fifoRd_q] : 32'h0000_0013;
  assign imem_req_addr_o = fetchPc_q;

  // Credit check counts owed responses plus buffered entries, freeing the slot popped this cycle.
  always_comb begin
    pop     = valid_o && !stall_i;
    room    = (({1'b0, inflight_q} + {1'b0, count_q}) - {{CW{1'b0}}, pop}) < DEPTH_W;
    imem_req_valid_o = !rst && !redirect_i && !blocked && room;
    reqFire = imem_req_valid_o && imem_req_ready_i;
    rspKeep = imem_rsp_valid_i && !redirect_i && (dropCnt_q == '0);
    rspDrop = imem_rsp_valid_i && !redirect_i && (dropCnt_q != '0);
  end

  // Next-state for PC, counters and queue pointers; a redirect overrides everything else.
  always_comb begin
    fetchPc_d  = fetchPc_q;
    inflight_d = inflight_q;
    dropCnt_d  = dropCnt_q;
    count_d    = count_q;
    fifoWr_d   = fifoWr_q;
    fifoRd_d   = fifoRd_q;
    pcqWr_d    = pcqWr_q;
    pcqRd_d    = pcqRd_q;
    if (redirect_i) begin
      fetchPc_d  = redirectTarget;
      inflight_d = inflight_q - CW'(imem_rsp_valid_i);
      dropCnt_d  = inflight_q - CW'(imem_rsp_valid_i);
      count_d    = '0;
      fifoWr_d   = '0;
      fifoRd_d   = '0;
      pcqWr_d    = '0;
      pcqRd_d    = '0;
    end else begin
      if (reqFire) begin
        fetchPc_d = fetchPc_q + 64'd4;
        pcqWr_d   = pcqWr_q + PW'(1);
      end
      inflight_d = inflight_q + CW'(reqFire) - CW'(imem_rsp_valid_i);
      if (rspDrop) dropCnt_d = dropCnt_q - CW'(1);
      if (rspKeep) begin
        fifoWr_d = fifoWr_q + PW'(1);
        pcqRd_d  = pcqRd_q + PW'(1);
      end
      if (pop) fifoRd_d = fifoRd_q + PW'(1);
      count_d = count_q + CW'(rspKeep) - CW'(pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc_q  <= RESET_PC;
      inflight_q <= '0;
      dropCnt_q  <= '0;
      count_q    <= '0;
      fifoWr_q   <= '0;
      fifoRd_q   <= '0;
      pcqWr_q    <= '0;
      pcqRd_q    <= '0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      inflight_q <= inflight_d;
      dropCnt_q  <= dropCnt_d;
      count_q    <= count_d;
      fifoWr_q   <= fifoWr_d;
      fifoRd_q   <= fifoRd_d;
      pcqWr_q    <= pcqWr_d;
      pcqRd_q    <= pcqRd_d;
    end
  end

  // Queue storage needs no reset: occupancy is tracked entirely by the pointers and counters.
  always_ff @(posedge clk) begin
    if (reqFire) pcQueue_q[pcqWr_q] <= fetchPc_q;
    if (rspKeep) begin
      fifoPc_q[fifoWr_q]    <= pcQueue_q[pcqRd_q];
      fifoInstr_q[fifoWr_q] <= imem_rsp_data_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit with an in-bench memory that
// answers after a configurable latency and an epoch-based model of expected outputs.
module tb_if_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          DEPTH    = 4;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [63:0] redirectPc;
  logic        reqValid;
  logic        reqReady;
  logic [63:0] reqAddr;
  logic        rspValid;
  logic [31:0] rspData;
  logic [63:0] pcOut;
  logic [31:0] instrOut;
  logic        validOut;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  typedef struct {
    logic [63:0] pc;
    int          epoch;
    int          due;
  } memEntry_t;

  memEntry_t   memQueue[$];
  logic [63:0] modelFifo[$];
  logic [63:0] expFetchPc = RESET_PC;
  int          epoch = 0;
  int          cycle = 0;
  int          latency = 1;
  bit          readyToggle = 1'b0;
  bit          expMisalign = 1'b0;
  bit          curRspValid = 1'b0;
  logic [63:0] curRspPc = '0;
  int          curRspEpoch = 0;
  int          checks = 0;
  int          errors = 0;

  bit          expPop;
  bit          expReq;
  bit          expFire;
  int          inflightNow;
  logic [63:0] dummyPc;
  memEntry_t   headEntry;

  if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirectPc),
    .imem_req_valid_o (reqValid),
    .imem_req_ready_i (reqReady),
    .imem_req_addr_o  (reqAddr),
    .imem_rsp_valid_i (rspValid),
    .imem_rsp_data_i  (rspData),
    .pc_o             (pcOut),
    .instr_o          (instrOut),
    .valid_o          (validOut)
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    .misalign_o       (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address so every PC has a distinct word.
  function automatic logic [31:0] instrOf(input logic [63:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hDEAD_0001;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  // One cycle of stimulus: drive control inputs and, if due, the next memory response.
  task automatic applyStimulus(input bit st, input bit rd, input logic [63:0] target);
    @(posedge clk);
    #1;
    cycle++;
    rst        = 1'b0;
    stall      = st;
    redirect   = rd;
    redirectPc = target;
    reqReady   = readyToggle ? ((cycle % 2) == 0) : 1'b1;
    if (memQueue.size() > 0 && memQueue[0].due <= cycle) begin
      headEntry   = memQueue.pop_front();
      curRspValid = 1'b1;
      curRspPc    = headEntry.pc;
      curRspEpoch = headEntry.epoch;
      rspValid    = 1'b1;
      rspData     = instrOf(headEntry.pc);
    end else begin
      curRspValid = 1'b0;
      rspValid    = 1'b0;
      rspData     = '0;
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirectPc  = '0;
    reqReady    = 1'b1;
    rspValid    = 1'b0;
    rspData     = '0;
    curRspValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_valid_o", validOut, 64'h0);
    checkOutput("reset_pc_o", pcOut, 64'h0);
    checkOutput("reset_instr_o", instrOut, 64'h13);
    @(posedge clk);
    cycle = -1;
  endtask

  // Compare process: check every output against the model, then advance the model one cycle.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("req_valid_in_reset", reqValid, 64'h0);
      memQueue.delete();
      modelFifo.delete();
      expFetchPc  = RESET_PC;
      epoch       = 0;
      expMisalign = 1'b0;
    end else begin
      expPop      = (modelFifo.size() > 0) && !stall;
      inflightNow = memQueue.size() + (curRspValid ? 1 : 0);
      expReq      = !redirect && !expMisalign &&
                    ((inflightNow + modelFifo.size() - (expPop ? 1 : 0)) < DEPTH);
      checkOutput("valid_o", validOut, (modelFifo.size() > 0) ? 64'h1 : 64'h0);
      checkOutput("pc_o", pcOut, (modelFifo.size() > 0) ? modelFifo[0] : 64'h0);
      checkOutput("instr_o", instrOut,
                  (modelFifo.size() > 0) ? {32'h0, instrOf(modelFifo[0])} : 64'h13);
      checkOutput("req_valid", reqValid, {63'h0, expReq});
      if (expReq) checkOutput("req_addr", reqAddr, expFetchPc);
`ifdef IFU_MISALIGN_CHECK_EN
      checkOutput("misalign_o", misalign, {63'h0, expMisalign});
`endif
      expFire = expReq && reqReady;
      if (redirect) begin
        modelFifo.delete();
        epoch++;
`ifdef IFU_MISALIGN_CHECK_EN
        expFetchPc  = redirectPc;
        expMisalign = (redirectPc[1:0] != 2'b00);
`else
        expFetchPc  = redirectPc & ~64'h3;
`endif
      end else begin
        if (expPop) dummyPc = modelFifo.pop_front();
        if (curRspValid && curRspEpoch == epoch) modelFifo.push_back(curRspPc);
        if (expFire) begin
          memQueue.push_back('{pc: expFetchPc, epoch: epoch, due: cycle + latency});
          expFetchPc = expFetchPc + 64'd4;
        end
      end
    end
  end

  // Watchdog so a wedged run still terminates with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence with hand-computed pins at key cycles.
  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirectPc = '0;
    reqReady = 1'b1;
    rspValid = 1'b0;
    rspData = '0;
    doReset();

    // zero-wait streaming from RESET_PC
    repeat (3) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("first_pc", pcOut, 64'h0000_0000_8000_0000);
    checkOutput("first_instr", instrOut, 64'hDEAD_8001);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("second_pc", pcOut, 64'h0000_0000_8000_0004);
    repeat (2) applyStimulus(1'b0, 1'b0, 64'h0);

    // stall held for 10 cycles freezes the head
    repeat (10) applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("stall_frozen_pc", pcOut, 64'h0000_0000_8000_0010);
    checkOutput("stall_frozen_instr", instrOut, 64'hDEBD_8001);
    repeat (2) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("after_stall_pc", pcOut, 64'h0000_0000_8000_0014);
    repeat (3) applyStimulus(1'b0, 1'b0, 64'h0);

    // fill the buffer under stall, then redirect while still stalled
    repeat (6) applyStimulus(1'b1, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b1, 64'h0000_0000_8000_2000);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("full_redirect_valid", validOut, 64'h0);
    repeat (2) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("full_redirect_pc", pcOut, 64'h0000_0000_8000_2000);
    repeat (4) applyStimulus(1'b0, 1'b0, 64'h0);

    // three-cycle memory: redirect with responses still owed and one arriving now
    latency = 3;
    repeat (10) applyStimulus(1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 64'h0000_0000_8000_1000);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("redirect_valid_t1", validOut, 64'h0);
    repeat (4) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("redirect_valid_t5", validOut, 64'h1);
    checkOutput("redirect_pc_t5", pcOut, 64'h0000_0000_8000_1000);

    // ready toggling with three-cycle memory
    readyToggle = 1'b1;
    repeat (40) applyStimulus(1'b0, 1'b0, 64'h0);
    readyToggle = 1'b0;
    latency = 1;
    repeat (5) applyStimulus(1'b0, 1'b0, 64'h0);

`ifdef IFU_MISALIGN_CHECK_EN
    applyStimulus(1'b0, 1'b1, 64'h0000_0000_8000_1002);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("misalign_set", misalign, 64'h1);
    repeat (3) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("misalign_held", misalign, 64'h1);
    applyStimulus(1'b0, 1'b1, 64'h0000_0000_8000_3000);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("misalign_clear", misalign, 64'h0);
    repeat (2) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("aligned_resume_pc", pcOut, 64'h0000_0000_8000_3000);
`else
    applyStimulus(1'b0, 1'b1, 64'h0000_0000_8000_1002);
    applyStimulus(1'b0, 1'b0, 64'h0);
    repeat (2) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("forced_align_pc", pcOut, 64'h0000_0000_8000_1000);
`endif
    repeat (4) applyStimulus(1'b0, 1'b0, 64'h0);

    // reset in the middle of traffic abandons everything owed
    latency = 2;
    repeat (5) applyStimulus(1'b0, 1'b0, 64'h0);
    latency = 1;
    doReset();
    repeat (3) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("rereset_first_pc", pcOut, 64'h0000_0000_8000_0000);
    repeat (3) applyStimulus(1'b0, 1'b0, 64'h0);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
